jtag_master: RTL and testbench
==============================

// Module: jtag_master
// PURPOSE
//   Host-side JTAG driver: generates TCK/TMS/TDI and samples TDO to run TAP-reset, IR-scan and DR-scan
//   commands against an IEEE 1149.1 target (our TAP target core). Sits between a system command port and the pins.
//   Assumes the target TAP rests in Run-Test/Idle between commands; every command returns it there.
// PARAMETERS
//   DATA_W   32  max scan length in bits; width of DATA_IN/DATA_OUT
//   CLK_DIV  2   CLK cycles per TCK half-period (>=1); TCK period = 2*CLK_DIV CLK cycles
//   LEN_W    derived localparam = $clog2(DATA_W+1)
// PORTS
//   CLK       in   1       system clock, the only clock
//   RST       in   1       asynchronous, active-high reset
//   START     in   1       command strobe, sampled on CLK rising edge
//   CMD       in   2       00 TAP reset, 01 IR scan, 10 DR scan, 11 reserved
//   LEN       in   LEN_W   scan length in bits (IR/DR only)
//   DATA_IN   in   DATA_W  bits to shift out on TDI, LSB first
//   DATA_OUT  out  DATA_W  bits captured from TDO, LSB = first bit shifted
//   BUSY      out  1       command in progress
//   DONE      out  1       one-CLK pulse at command completion
//   TCK       out  1       JTAG test clock
//   TMS       out  1       JTAG mode select
//   TDI       out  1       JTAG data to target
//   TDO       in   1       JTAG data from target
// BEHAVIOUR
//   Reset: TCK=0, TMS=0, TDI=0, BUSY=0, DONE=0, DATA_OUT=0, FSM=IDLE, divider=0. Reset mid-command aborts at
//     once; target TAP state is then undefined and the host must issue CMD=00 before any scan.
//   Accept: START=1 && BUSY=0 in IDLE latches CMD/LEN/DATA_IN; BUSY=1 next cycle. START while BUSY ignored.
//     CMD=11 or (scan with LEN=0) ignored: no BUSY, no DONE. LEN>DATA_W clamped to DATA_W.
//   Bit timing: each JTAG bit = one TCK period. Cycle after accept, TMS/TDI for bit 0 driven with TCK=0;
//     held CLK_DIV cycles, then TCK=1 for CLK_DIV cycles; TDO sampled on the CLK edge that raises TCK;
//     TCK falls and TMS/TDI update to the next bit on the same edge. TMS/TDI never change while TCK=1.
//   FSM: IDLE -> {RST_SEQ | PRE} -> SHIFT -> POST -> IDLE.
//     RST_SEQ (CMD 00): TMS = 1,1,1,1,1,0 (6 bits) -> Test-Logic-Reset then Run-Test/Idle. TDI=0.
//     PRE IR (CMD 01): TMS = 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR). TDI=0.
//     PRE DR (CMD 10): TMS = 1,0,0   (Select-DR, Capture-DR, Shift-DR). TDI=0.
//     SHIFT: LEN bits; TDI = DATA_IN[i]; TMS=0 for i<LEN-1, TMS=1 on i=LEN-1 (-> Exit1);
//       TDO sampled during bit i -> DATA_OUT[i]. Bits >= LEN of DATA_OUT = 0.
//     POST: TMS = 1,0 (Update, Run-Test/Idle). TDI=0.
//   Bit count N: TAP reset 6; IR 6+LEN; DR 5+LEN.
//   Latency: DONE=1, BUSY=0 exactly N*2*CLK_DIV+1 CLK cycles after the accepting edge; TCK=0 then.
//   DATA_OUT updates only while shifting; stable from DONE until the next accepted scan command
//     (TAP reset leaves DATA_OUT unchanged). A new START may be accepted in the DONE cycle.
//   Idle: TCK=0, TMS=0, TDI=0; no TCK edges outside a command.
//   Divider: counter 0..CLK_DIV-1, cleared on accept and in IDLE; CLK_DIV=1 gives TCK=CLK/2.
// TESTING
//   CLK_DIV=2, CMD=00 -> 6 TCK pulses, TMS per bit 1,1,1,1,1,0; DONE at cycle 25; TCK=0 when idle after.
//   CMD=01 LEN=4 DATA_IN=4'hF -> TMS 1,1,0,0,0,0,0,1,1,0; TDI bits 0,0,0,0,1,1,1,1,0,0; DONE at 41.
//   TAP target model, IR=4'hF (BYPASS) then DR LEN=8 DATA_IN=8'hA5 -> DATA_OUT=8'h4A (1-bit bypass delay).
//   START pulsed while BUSY, CMD=11, and LEN=0 scan -> no extra BUSY/DONE, pins unchanged.
//   RST asserted mid-SHIFT of DR LEN=32 -> all outputs at reset values next cycle; CMD=00 then IR/DR works.
//   CLK_DIV=1, DR LEN=32 loopback (TDO=TDI sampled) -> DATA_OUT=DATA_IN; DONE at 75; no TMS/TDI change at TCK=1.

Source files
------------

// File: rtl/jtag_master_if.sv
// rtl/jtag_master_if.sv - command port and JTAG pin bundle for jtag_master
interface jtag_master_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(DATA_W + 1)
);
    logic              start;
    logic [1:0]        cmd;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;
    logic              tck;
    logic              tms;
    logic              tdi;
    logic              tdo;

    modport master (
        output start, cmd, len, data_in, tdo,
        input  data_out, busy, done, tck, tms, tdi
    );

    modport slave (
        input  start, cmd, len, data_in, tdo,
        output data_out, busy, done, tck, tms, tdi
    );
endinterface

// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - JTAG host driver sequencing TAP reset, IR scan and DR scan
module jtag_master #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 2
) (
    input  logic         clk,
    input  logic         rst,
    jtag_master_if.slave bus
);
    localparam int LEN_W = $clog2(DATA_W + 1);
    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_SEQ, S_PRE, S_SHIFT, S_POST, S_DONE
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  idx, idx_n, phase_len;
    logic [DIV_W-1:0]  div_cnt;
    logic [LEN_W-1:0]  len_q, len_n, len_c;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_out_q;
    logic              is_ir, ir_n;
    logic              tck_q, tms_q, tdi_q, busy_q, done_q;
    logic              active, half_end, rise, fall, last_bit, cmd_ok, accept;
    logic              tms_n, tdi_n;

    // Next-state, bit-phase bookkeeping and the TMS/TDI value for the upcoming bit
    always_comb begin
        active   = (state == S_RST_SEQ) || (state == S_PRE) ||
                   (state == S_SHIFT) || (state == S_POST);
        half_end = (div_cnt == DIV_LAST);
        rise     = active && !tck_q && half_end;
        fall     = active && tck_q && half_end;
        len_c    = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
        cmd_ok   = (bus.cmd == 2'b00) || ((bus.cmd != 2'b11) && (bus.len != '0));
        accept   = (state == S_IDLE) && bus.start && cmd_ok;
        ir_n     = accept ? (bus.cmd == 2'b01) : is_ir;
        len_n    = accept ? len_c : len_q;

        case (state)
            S_RST_SEQ: phase_len = CNT_W'(6);
            S_PRE:     phase_len = is_ir ? CNT_W'(4) : CNT_W'(3);
            S_SHIFT:   phase_len = CNT_W'(len_q);
            S_POST:    phase_len = CNT_W'(2);
            default:   phase_len = CNT_W'(1);
        endcase
        last_bit = (idx == phase_len - CNT_W'(1));

        state_n = state;
        idx_n   = idx;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = (bus.cmd == 2'b00) ? S_RST_SEQ : S_PRE;
                    idx_n   = '0;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: begin
                if (fall) begin
                    if (last_bit) begin
                        idx_n = '0;
                        case (state)
                            S_PRE:   state_n = S_SHIFT;
                            S_SHIFT: state_n = S_POST;
                            default: state_n = S_DONE;
                        endcase
                    end else begin
                        idx_n = idx + CNT_W'(1);
                    end
                end
            end
        endcase

        // TMS walks the TAP from Run-Test/Idle into Shift and back again
        case (state_n)
            S_RST_SEQ: tms_n = (idx_n < CNT_W'(5));
            S_PRE:     tms_n = ir_n ? (idx_n < CNT_W'(2)) : (idx_n == '0);
            S_SHIFT:   tms_n = (idx_n == CNT_W'(len_n) - CNT_W'(1));
            S_POST:    tms_n = (idx_n == '0);
            default:   tms_n = 1'b0;
        endcase
        tdi_n = (state_n == S_SHIFT) && (|(data_q & (DATA_W'(1) << idx_n)));
    end

    // FSM state and bit index within the current phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // TCK divider, pin registers, command latches and TDO capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b0;
            tdi_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
            data_q     <= '0;
            len_q      <= '0;
            is_ir      <= 1'b0;
        end else begin
            busy_q <= (state_n != S_IDLE);
            done_q <= (state == S_DONE);
            if (!active || half_end) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (active && half_end) begin
                tck_q <= !tck_q;
            end
            // TMS/TDI only move with TCK low: at accept or on the falling edge
            if (accept || fall) begin
                tms_q <= tms_n;
                tdi_q <= tdi_n;
            end
            if (accept) begin
                data_q <= bus.data_in;
                len_q  <= len_c;
                is_ir  <= ir_n;
            end
            // First shifted bit clears the stale upper bits of the previous scan
            if (rise && (state == S_SHIFT)) begin
                data_out_q <= ((idx == '0) ? '0 : data_out_q) | (DATA_W'(bus.tdo) << idx);
            end
        end
    end

    assign bus.tck      = tck_q;
    assign bus.tms      = tms_q;
    assign bus.tdi      = tdi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_jtag_master.sv
// tb/tb_jtag_master.sv - scoreboard bench for jtag_master with a behavioural TAP target
module tb_jtag_master;
    localparam int DW = 32;
    localparam int LW = $clog2(DW + 1);
    localparam logic [DW-1:0] IDCODE = 32'h4BA0_0477;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtag_master_if #(.DATA_W(DW)) ifa();
    jtag_master_if #(.DATA_W(DW)) ifb();

    jtag_master #(.DATA_W(DW), .CLK_DIV(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    jtag_master #(.DATA_W(DW), .CLK_DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic          sel = 1'b0;
    logic          t_start = 1'b0;
    logic [1:0]    t_cmd = 2'b00;
    logic [LW-1:0] t_len = '0;
    logic [DW-1:0] t_din = '0;
    logic          tgt_tdo = 1'b0;

    assign ifa.start   = t_start && !sel;
    assign ifb.start   = t_start && sel;
    assign ifa.cmd     = t_cmd;
    assign ifb.cmd     = t_cmd;
    assign ifa.len     = t_len;
    assign ifb.len     = t_len;
    assign ifa.data_in = t_din;
    assign ifb.data_in = t_din;
    assign ifa.tdo     = tgt_tdo;
    assign ifb.tdo     = ifb.tdi;

    logic          m_busy, m_done, m_tck, m_tms, m_tdi;
    logic [DW-1:0] m_out;
    assign m_busy = sel ? ifb.busy : ifa.busy;
    assign m_done = sel ? ifb.done : ifa.done;
    assign m_tck  = sel ? ifb.tck  : ifa.tck;
    assign m_tms  = sel ? ifb.tms  : ifa.tms;
    assign m_tdi  = sel ? ifb.tdi  : ifa.tdi;
    assign m_out  = sel ? ifb.data_out : ifa.data_out;

    // ---------------- TAP target: 4-bit IR, IR=F BYPASS, anything else IDCODE ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SDS, CDR, SDR, E1D, PDR, E2D, UDR, SIS, CIR, SIR, E1I, PIR, E2I, UIR
    } tap_t;
    tap_t          tap = TLR;
    logic [3:0]    t_ir = 4'h1;
    logic [3:0]    t_irsr = 4'h0;
    logic [DW-1:0] t_dsr = '0;
    logic          t_byp = 1'b0;

    function automatic tap_t next_tap(input tap_t s, input logic m);
        case (s)
            TLR: return m ? TLR : RTI;
            RTI: return m ? SDS : RTI;
            SDS: return m ? SIS : CDR;
            CDR: return m ? E1D : SDR;
            SDR: return m ? E1D : SDR;
            E1D: return m ? UDR : PDR;
            PDR: return m ? E2D : PDR;
            E2D: return m ? UDR : SDR;
            UDR: return m ? SDS : RTI;
            SIS: return m ? TLR : CIR;
            CIR: return m ? E1I : SIR;
            SIR: return m ? E1I : SIR;
            E1I: return m ? UIR : PIR;
            PIR: return m ? E2I : PIR;
            E2I: return m ? UIR : SIR;
            default: return m ? SDS : RTI;
        endcase
    endfunction

    always @(posedge ifa.tck) begin
        case (tap)
            TLR: t_ir <= 4'h1;
            CIR: t_irsr <= 4'b0001;
            SIR: t_irsr <= {ifa.tdi, t_irsr[3:1]};
            UIR: t_ir <= t_irsr;
            CDR: begin t_byp <= 1'b0; t_dsr <= IDCODE; end
            SDR: begin t_byp <= ifa.tdi; t_dsr <= {ifa.tdi, t_dsr[DW-1:1]}; end
            default: ;
        endcase
        tap <= next_tap(tap, ifa.tms);
    end

    always @(negedge ifa.tck) begin
        tgt_tdo <= (tap == SIR) ? t_irsr[0] :
                   (tap == SDR) ? ((t_ir == 4'hF) ? t_byp : t_dsr[0]) : 1'b0;
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [63:0]   tms;
        logic [63:0]   tdi;
        int            n;
        logic [DW-1:0] out;
        int            lat;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          m_e;
    logic [3:0]    ir_ref = 4'h1;
    logic [DW-1:0] last_out = '0;
    int            checks = 0;
    int            errors = 0;

    function automatic exp_t model(input logic [1:0] c, input int l_in, input logic [DW-1:0] d,
                                   input int div, input bit loop);
        exp_t        e;
        int          l;
        int          n;
        logic [63:0] mask;
        l = (l_in > DW) ? DW : l_in;
        e.tms = '0;
        e.tdi = '0;
        n = 0;
        if (c == 2'b00) begin
            for (int i = 0; i < 6; i++) begin e.tms[n] = (i < 5); n++; end
            ir_ref = 4'h1;
            e.out  = last_out;
        end else begin
            for (int i = 0; i < ((c == 2'b01) ? 4 : 3); i++) begin
                e.tms[n] = (i == 0) || ((c == 2'b01) && (i == 1));
                n++;
            end
            for (int i = 0; i < l; i++) begin
                e.tms[n] = (i == l - 1);
                e.tdi[n] = d[i];
                n++;
            end
            e.tms[n] = 1'b1;
            n += 2;
            mask = (64'd1 << l) - 64'd1;
            if (loop) begin
                e.out = DW'(64'(d) & mask);
            end else if (c == 2'b01) begin
                e.out  = DW'(((64'(d) << 4) | 64'd1) & mask);
                ir_ref = 4'(64'(d) >> (l - 4));
            end else if (ir_ref == 4'hF) begin
                e.out = DW'((64'(d) << 1) & mask);
            end else begin
                e.out = DW'(64'(IDCODE) & mask);
            end
            last_out = e.out;
        end
        e.n   = n;
        e.lat = n * 2 * div + 1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] c, input int l, input logic [DW-1:0] d);
        if ((c != 2'b11) && ((c == 2'b00) || (l != 0)))
            exp_q.push_back(model(c, l, d, sel ? 1 : 2, sel));
        t_cmd   = c;
        t_len   = LW'(l);
        t_din   = d;
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
    endtask

    task automatic finish_cmd();
        int t;
        t = 0;
        while (m_busy && (t < 400)) begin @(negedge clk); t++; end
        checks++;
        if (m_busy) begin
            errors++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, expected 0", t);
        end
    endtask

    task automatic idle_check(input string name);
        repeat (4) @(negedge clk);
        chk({name, "_pins"}, {59'd0, m_busy, m_done, m_tck, m_tms, m_tdi}, 64'd0);
        chk({name, "_out"}, m_out, last_out);
    endtask

    // Monitor: records TMS/TDI at each TCK rise and scores every DONE against the queue
    int          cyc = 0;
    int          nb = 0;
    bit          glitch = 0;
    bit          p_busy = 0, p_tck = 0, p_tms = 0, p_tdi = 0;
    logic [63:0] g_tms = '0, g_tdi = '0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            cyc = 0; nb = 0; glitch = 0;
            p_busy = 0; p_tck = 0; p_tms = 0; p_tdi = 0;
        end else begin
            if (m_busy && !p_busy) begin
                cyc = 0; nb = 0; glitch = 0; g_tms = '0; g_tdi = '0;
            end else begin
                cyc++;
            end
            if (m_tck && !p_tck && (nb < 64)) begin
                g_tms[nb] = m_tms;
                g_tdi[nb] = m_tdi;
                nb++;
            end
            if (m_tck && p_tck && ((m_tms != p_tms) || (m_tdi != p_tdi))) glitch = 1;
            if (m_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done with no command outstanding, data_out=%0h", m_out);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("bit_count", 64'(nb), 64'(m_e.n));
                    chk("tms_seq", g_tms, m_e.tms);
                    chk("tdi_seq", g_tdi, m_e.tdi);
                    chk("data_out", 64'(m_out), 64'(m_e.out));
                    chk("latency", 64'(cyc), 64'(m_e.lat));
                    chk("end_state", {59'd0, glitch, m_busy, m_tck, m_tms, m_tdi}, 64'd0);
                end
            end
            p_busy = m_busy; p_tck = m_tck; p_tms = m_tms; p_tdi = m_tdi;
        end
    end

    // Stimulus
    initial begin
        int            c;
        int            l;
        logic [DW-1:0] d;

        repeat (3) @(negedge clk);
        chk("reset_pins_a", {59'd0, ifa.busy, ifa.done, ifa.tck, ifa.tms, ifa.tdi}, 64'd0);
        chk("reset_out_a", 64'(ifa.data_out), 64'd0);
        chk("reset_pins_b", {59'd0, ifb.busy, ifb.done, ifb.tck, ifb.tms, ifb.tdi}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 0, '0);            finish_cmd();
        issue(2'b01, 4, 32'hF);         finish_cmd();
        issue(2'b10, 8, 32'hA5);        finish_cmd();
        chk("bypass_a5", 64'(m_out), 64'h4A);

        issue(2'b10, 16, $urandom);
        t_cmd = 2'b00; t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        finish_cmd();
        issue(2'b11, 8, $urandom);      idle_check("cmd11");
        issue(2'b10, 0, $urandom);      idle_check("len0");

        for (int k = 0; k < 24; k++) begin
            c = $urandom_range(0, 2);
            d = $urandom;
            if (c == 1) begin
                l = $urandom_range(4, 12);
                if ($urandom_range(0, 1) == 1) d = '1;
            end else begin
                l = $urandom_range(1, 40);
            end
            issue(2'(c), l, d);
            finish_cmd();
        end

        issue(2'b10, 32, $urandom);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        last_out = '0;
        @(negedge clk);
        chk("abort_pins", {59'd0, ifa.busy, ifa.done, ifa.tck, ifa.tms, ifa.tdi}, 64'd0);
        chk("abort_out", 64'(ifa.data_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        issue(2'b00, 0, '0);            finish_cmd();
        issue(2'b01, 4, 32'hF);         finish_cmd();
        issue(2'b10, 8, $urandom);      finish_cmd();
        issue(2'b01, 4, 32'h1);         finish_cmd();
        issue(2'b10, 32, $urandom);     finish_cmd();

        repeat (2) @(negedge clk);
        sel = 1'b1;
        last_out = '0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            l = (k < 3) ? 32 : $urandom_range(1, 40);
            issue(2'b10, l, $urandom);
            finish_cmd();
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
